// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, token selection and disparity type.
package tmds_pkg;

  localparam logic [9:0] CTRLTOKEN0 = 10'h354;
  localparam logic [9:0] CTRLTOKEN1 = 10'h0AB;
  localparam logic [9:0] CTRLTOKEN2 = 10'h154;
  localparam logic [9:0] CTRLTOKEN3 = 10'h2AB;

  // Running disparity: 5-bit two's complement, legal range -8..+8.
  typedef logic signed [4:0] disp_t;

  // Map {C1,C0} to the control token sent during blanking.
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = CTRLTOKEN0;
      2'b01:   tok = CTRLTOKEN1;
      2'b10:   tok = CTRLTOKEN2;
      2'b11:   tok = CTRLTOKEN3;
      default: tok = CTRLTOKEN0;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Pixel-side bus of one TMDS channel: DE/C0/C1/data in, character and blank flag out.
interface tmds_encoder_if;
  logic       pde;
  logic       pc0;
  logic       pc1;
  logic [7:0] pdata;
  logic [9:0] pq;
  logic       pblank_short;

  modport master (output pde, pc0, pc1, pdata, input pq, pblank_short);
  modport slave  (input pde, pc0, pc1, pdata, output pq, pblank_short);
endinterface

// File: rtl/tmds_ones8.sv
// Combinational population count of an 8-bit word.
module tmds_ones8 (
  input  logic [7:0] d_i,
  output logic [3:0] n_o
);

  // Sum the set bits of the input word
  always_comb begin
    n_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n_o = n_o + {3'b000, d_i[i]};
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// Single-channel DVI/TMDS 8b/10b encoder with blanking-length monitor.
// Pipeline: input register -> stage 1 (q_m) -> stage 2 (n1q/n0q) -> stage 3 (pq, disparity).
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int kMinBlank = 300
) (
  input  logic          pixelclk,
  input  logic          prst_n,
  tmds_encoder_if.slave bus
);

  localparam int              BW        = $clog2(kMinBlank + 1);
  localparam logic [BW-1:0]   BLANK_MAX = BW'(kMinBlank);

  // Input register
  logic       de0_q;
  logic [1:0] c0_q;
  logic [7:0] d0_q;
  // Stage 1 register
  logic       de1_q;
  logic [1:0] c1_q;
  logic [8:0] qm1_q;
  // Stage 2 register
  logic       de2_q;
  logic [1:0] c2_q;
  logic [8:0] qm2_q;
  logic [3:0] n1q2_q;
  logic [3:0] n0q2_q;
  // Stage 3 / output register
  logic [9:0]    pq_q,    pq_d;
  disp_t         disp_q,  disp_d;
  logic          de3_q;
  logic [BW-1:0] blank_q, blank_d;
  logic          pulse_q, pulse_d;

  // Combinational intermediates
  logic [3:0] n1d_s;
  logic [3:0] n1q_s;
  logic       use_xnor_s;
  logic [8:0] qm_s;
  disp_t      diff_s;
  disp_t      two_s;
  disp_t      two_n_s;

  tmds_ones8 u_ones_d (.d_i(d0_q),       .n_o(n1d_s));
  tmds_ones8 u_ones_q (.d_i(qm1_q[7:0]), .n_o(n1q_s));

  // Stage 1: transition minimisation, XNOR chain for dense words, XOR otherwise
  always_comb begin
    use_xnor_s = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && (d0_q[0] == 1'b0));
    qm_s       = 9'd0;
    qm_s[0]    = d0_q[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor_s) begin
        qm_s[i] = ~(qm_s[i-1] ^ d0_q[i]);
      end else begin
        qm_s[i] = qm_s[i-1] ^ d0_q[i];
      end
    end
    qm_s[8] = ~use_xnor_s;
  end

  // Stage 3: DC balancing on data, control tokens and disparity reset on blanking
  always_comb begin
    diff_s  = disp_t'({1'b0, n1q2_q}) - disp_t'({1'b0, n0q2_q});
    two_s   = qm2_q[8] ? 5'sd2 : 5'sd0;
    two_n_s = qm2_q[8] ? 5'sd0 : 5'sd2;
    pq_d    = CTRLTOKEN0;
    disp_d  = disp_q;
    if (!de2_q) begin
      pq_d   = ctrl_token(c2_q);
      disp_d = 5'sd0;
    end else if ((disp_q == 5'sd0) || (n1q2_q == n0q2_q)) begin
      pq_d = {~qm2_q[8], qm2_q[8], qm2_q[8] ? qm2_q[7:0] : ~qm2_q[7:0]};
      if (qm2_q[8]) begin
        disp_d = disp_q + diff_s;
      end else begin
        disp_d = disp_q - diff_s;
      end
    end else if ((!disp_q[4] && (n1q2_q > n0q2_q)) || (disp_q[4] && (n0q2_q > n1q2_q))) begin
      pq_d   = {1'b1, qm2_q[8], ~qm2_q[7:0]};
      disp_d = disp_q + two_s - diff_s;
    end else begin
      pq_d   = {1'b0, qm2_q[8], qm2_q[7:0]};
      disp_d = disp_q + diff_s - two_n_s;
    end
  end

  // Blank monitor: saturating count of stage-3 blanking, flag short intervals on DE rise
  always_comb begin
    blank_d = blank_q;
    pulse_d = 1'b0;
    if (de2_q) begin
      if (!de3_q) begin
        pulse_d = (blank_q < BLANK_MAX);
      end else begin
        pulse_d = 1'b0;
      end
      blank_d = '0;
    end else begin
      if (blank_q < BLANK_MAX) begin
        blank_d = blank_q + BW'(1);
      end else begin
        blank_d = blank_q;
      end
    end
  end

  // Input, stage 1 and stage 2 pipeline registers; reset discards contents as blanking C=00
  always_ff @(posedge pixelclk) begin
    if (!prst_n) begin
      de0_q  <= 1'b0;
      c0_q   <= 2'b00;
      d0_q   <= 8'h00;
      de1_q  <= 1'b0;
      c1_q   <= 2'b00;
      qm1_q  <= 9'h000;
      de2_q  <= 1'b0;
      c2_q   <= 2'b00;
      qm2_q  <= 9'h000;
      n1q2_q <= 4'd0;
      n0q2_q <= 4'd0;
    end else begin
      de0_q  <= bus.pde;
      c0_q   <= {bus.pc1, bus.pc0};
      d0_q   <= bus.pdata;
      de1_q  <= de0_q;
      c1_q   <= c0_q;
      qm1_q  <= qm_s;
      de2_q  <= de1_q;
      c2_q   <= c1_q;
      qm2_q  <= qm1_q;
      n1q2_q <= n1q_s;
      n0q2_q <= 4'd8 - n1q_s;
    end
  end

  // Stage 3 registers: output character, running disparity and blank monitor state
  always_ff @(posedge pixelclk) begin
    if (!prst_n) begin
      pq_q    <= CTRLTOKEN0;
      disp_q  <= 5'sd0;
      de3_q   <= 1'b0;
      blank_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      pq_q    <= pq_d;
      disp_q  <= disp_d;
      de3_q   <= de2_q;
      blank_q <= blank_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.pq           = pq_q;
  assign bus.pblank_short = pulse_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed scenarios plus randomized stream
// against a behavioural model working on whole words with integer arithmetic.
module tb_tmds_encoder;

  localparam int K = 300;

  logic clk;
  logic rst_n;
  tmds_encoder_if bus ();

  tmds_encoder #(.kMinBlank(K)) u_dut (
    .pixelclk(clk),
    .prst_n  (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state
  logic [9:0] tok [4];
  bit         m_de [3];
  logic [1:0] m_c  [3];
  logic [7:0] m_d  [3];
  int         m_cnt;
  int         m_blank;
  bit         m_prev_de;
  logic [9:0] exp_pq;
  bit         exp_pulse;

  // Advance the reference by one pixel clock given the inputs just sampled
  task automatic model_step(input bit r, input bit de, input logic [1:0] c, input logic [7:0] d);
    bit         ede;
    logic [1:0] ec;
    logic [7:0] ed;
    int         ones, n1, n0, pre, qm8;
    bit         xn;
    logic [7:0] qm;
    if (!r) begin
      for (int i = 0; i < 3; i++) begin
        m_de[i] = 1'b0; m_c[i] = 2'b00; m_d[i] = 8'h00;
      end
      m_cnt = 0; m_blank = 0; m_prev_de = 1'b0;
      exp_pq = 10'h354; exp_pulse = 1'b0;
    end else begin
      ede = m_de[2]; ec = m_c[2]; ed = m_d[2];
      if (!ede) begin
        exp_pq = tok[ec];
        m_cnt  = 0;
      end else begin
        ones = $countones(ed);
        xn   = (ones > 4) || (ones == 4 && ed[0] == 1'b0);
        // q_m[i] is the parity of D[i:0], inverted on odd positions for the XNOR chain
        for (int i = 0; i < 8; i++) begin
          pre   = $countones(int'(ed) & ((1 << (i + 1)) - 1)) % 2;
          qm[i] = (pre == 1) ^ (xn && (i % 2 == 1));
        end
        qm8 = xn ? 0 : 1;
        n1  = $countones(qm);
        n0  = 8 - n1;
        if (m_cnt == 0 || n1 == n0) begin
          if (qm8 == 1) begin
            exp_pq = {2'b01, qm};
            m_cnt  = m_cnt + n1 - n0;
          end else begin
            exp_pq = {2'b10, ~qm};
            m_cnt  = m_cnt + n0 - n1;
          end
        end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
          exp_pq = {1'b1, qm8[0], ~qm};
          m_cnt  = m_cnt + 2 * qm8 + n0 - n1;
        end else begin
          exp_pq = {1'b0, qm8[0], qm};
          m_cnt  = m_cnt + n1 - n0 - 2 * (1 - qm8);
        end
      end
      if (ede) begin
        exp_pulse = !m_prev_de && (m_blank < K);
        m_blank   = 0;
      end else begin
        exp_pulse = 1'b0;
        if (m_blank < K) m_blank = m_blank + 1;
      end
      m_prev_de = ede;
      for (int i = 2; i > 0; i--) begin
        m_de[i] = m_de[i-1]; m_c[i] = m_c[i-1]; m_d[i] = m_d[i-1];
      end
      m_de[0] = de; m_c[0] = c; m_d[0] = d;
    end
  endtask

  // Drive one cycle of inputs, clock it in, update the model, settle before sampling
  task automatic tick(input bit r, input bit de, input logic [1:0] c, input logic [7:0] d);
    rst_n     = r;
    bus.pde   = de;
    bus.pc0   = c[0];
    bus.pc1   = c[1];
    bus.pdata = d;
    @(posedge clk);
    model_step(r, de, c, d);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 2'b00, 8'h00);
      tests_run++;
      if (bus.pq !== 10'h354) begin
        tests_failed++;
        $display("FAIL reset_pq cyc=%0d got=%h exp=354", i, bus.pq);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 2'b00, 8'h00);
      tests_run++;
      if (bus.pq !== 10'h354 || bus.pblank_short !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle pq/blank cyc=%0d got=%h/%b exp=354/0", i, bus.pq, bus.pblank_short);
      end
    end
  endtask

  task automatic test_ctrl_tokens();
    logic [9:0] got [7];
    logic [1:0] cs  [7];
    cs = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b0, cs[i], 8'($urandom));
      got[i] = bus.pq;
    end
    tests_run++;
    if (got[3] !== 10'h0AB) begin tests_failed++; $display("FAIL token01 got=%h exp=0ab", got[3]); end
    tests_run++;
    if (got[4] !== 10'h154) begin tests_failed++; $display("FAIL token10 got=%h exp=154", got[4]); end
    tests_run++;
    if (got[5] !== 10'h2AB) begin tests_failed++; $display("FAIL token11 got=%h exp=2ab", got[5]); end
    tests_run++;
    if (got[6] !== 10'h354) begin tests_failed++; $display("FAIL token00 got=%h exp=354", got[6]); end
  endtask

  task automatic test_disparity();
    logic [9:0] got_q [6];
    int         got_c [6];
    logic [9:0] eq [3];
    int         ec [3];
    eq = '{10'h100, 10'h3FF, 10'h100};
    ec = '{-8, 2, -6};
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 2'b00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, (i < 3), 2'b00, 8'h00);
      got_q[i] = bus.pq;
      got_c[i] = int'(u_dut.disp_q);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (got_q[i+3] !== eq[i] || got_c[i+3] != ec[i]) begin
        tests_failed++;
        $display("FAIL disparity word%0d got=%h cnt=%0d exp=%h cnt=%0d", i, got_q[i+3], got_c[i+3], eq[i], ec[i]);
      end
    end
  endtask

  task automatic test_xnor();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 2'b00, 8'h00);
    tick(1'b1, 1'b1, 2'b00, 8'hFF);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 2'b00, 8'h00);
    tests_run++;
    if (bus.pq !== 10'h200 || int'(u_dut.disp_q) != -8) begin
      tests_failed++;
      $display("FAIL xnor_ff got=%h cnt=%0d exp=200 cnt=-8", bus.pq, int'(u_dut.disp_q));
    end
  endtask

  task automatic test_blank_monitor();
    int seg_de  [7];
    int seg_len [7];
    int t, pulses, pulse_at;
    seg_de  = '{1, 0, 1, 0, 1, 0, 1};
    seg_len = '{5, 10, 5, 300, 5, 1000, 8};
    t = 0; pulses = 0; pulse_at = -1;
    for (int s = 0; s < 7; s++) begin
      for (int j = 0; j < seg_len[s]; j++) begin
        tick(1'b1, seg_de[s] == 1, 2'($urandom), 8'($urandom));
        tests_run++;
        if (bus.pblank_short !== exp_pulse || bus.pq !== exp_pq) begin
          tests_failed++;
          $display("FAIL blank_mon t=%0d got=%b/%h exp=%b/%h", t, bus.pblank_short, bus.pq, exp_pulse, exp_pq);
        end
        if (s >= 1 && bus.pblank_short === 1'b1) begin
          pulses++;
          pulse_at = t;
        end
        t++;
      end
    end
    tests_run++;
    if (pulses != 1 || pulse_at != 18) begin
      tests_failed++;
      $display("FAIL blank_pulses got=%0d at=%0d exp=1 at=18", pulses, pulse_at);
    end
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 2'b00, 8'($urandom));
    tick(1'b0, 1'b1, 2'b00, 8'($urandom));
    tests_run++;
    if (bus.pq !== 10'h354 || int'(u_dut.disp_q) != 0) begin
      tests_failed++;
      $display("FAIL mid_reset got=%h cnt=%0d exp=354 cnt=0", bus.pq, int'(u_dut.disp_q));
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1, 2'b00, (i == 0) ? 8'h00 : 8'($urandom));
      if (i < 3) begin
        tests_run++;
        if (bus.pq !== 10'h354) begin
          tests_failed++;
          $display("FAIL post_reset_hold cyc=%0d got=%h exp=354", i, bus.pq);
        end
      end else if (i == 3) begin
        tests_run++;
        if (bus.pq !== 10'h100) begin
          tests_failed++;
          $display("FAIL post_reset_first got=%h exp=100", bus.pq);
        end
      end else begin
        tests_run++;
        if (bus.pq !== exp_pq) begin
          tests_failed++;
          $display("FAIL post_reset_stream cyc=%0d got=%h exp=%h", i, bus.pq, exp_pq);
        end
      end
    end
  endtask

  task automatic test_random();
    bit de;
    int dsp;
    for (int i = 0; i < 10000; i++) begin
      if (i < 400)       de = (i % 2 == 1);
      else if (i < 2000) de = ($urandom_range(0, 3) != 0);
      else               de = ($urandom_range(0, 31) != 0);
      tick(1'b1, de, 2'($urandom), 8'($urandom));
      dsp = int'(u_dut.disp_q);
      tests_run++;
      if (bus.pq !== exp_pq || bus.pblank_short !== exp_pulse || dsp != m_cnt || dsp > 8 || dsp < -8) begin
        tests_failed++;
        $display("FAIL random i=%0d got=%h/%b cnt=%0d exp=%h/%b cnt=%0d", i, bus.pq, bus.pblank_short, dsp, exp_pq, exp_pulse, m_cnt);
      end
    end
  endtask

  initial begin
    tok = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    rst_n = 1'b0;
    bus.pde = 1'b0; bus.pc0 = 1'b0; bus.pc1 = 1'b0; bus.pdata = 8'h00;
    model_step(1'b0, 1'b0, 2'b00, 8'h00);
    test_reset();
    test_ctrl_tokens();
    test_disparity();
    test_xnor();
    test_blank_monitor();
    test_midstream_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

Single-channel DVI/TMDS 8b/10b encoder for the HDMI transmit path. It is the transmit-side counterpart of the receive-side alignment logic. It turns one 8-bit colour component plus DE/C0/C1 into a DC-balanced 10-bit TMDS character, and emits the four standard control tokens during blanking. A blanking-length monitor flags blanking intervals too short for a sink to word-align on control tokens. Three instances, one per channel, feed the 10:1 serializers.

## Interface
- `kMinBlank`, default 300: minimum consecutive control-token cycles a sink needs to align; shorter blanking is flagged.
- `pixelclk` in 1: pixel clock. This is the only clock.
- `prst_n` in 1: reset. Synchronous, active-low.
- `pde` in 1: data enable. 1 selects video data, 0 selects a control token.
- `pc0` in 1: control bit 0, sampled when `pde`=0.
- `pc1` in 1: control bit 1, sampled when `pde`=0.
- `pdata` in 8: pixel component, sampled when `pde`=1.
- `pq` out 10: encoded TMDS character. Bit 0 is transmitted first.
- `pblank_short` out 1: one-cycle pulse when a blanking interval ends before `kMinBlank` tokens were sent.

## Operation
- **Reset values:**
  - `pq`=10'h354.
  - `pblank_short`=0.
  - Running disparity `cnt`=0.
  - Pipeline DE=0 and C=00.
  - Blank counter=0.
- **Control path** (DE=0), token selected by {C1,C0}:
  - 00 → 10'h354
  - 01 → 10'h0AB
  - 10 → 10'h154
  - 11 → 10'h2AB
  - `cnt` is forced to 0.
- **Stage 1 (transition minimisation):**
  - n1d = popcount(D).
  - If n1d>4, or n1d==4 with D[0]==0, use XNOR: q_m[0]=D[0], q_m[i]=~(q_m[i-1]^D[i]), q_m[8]=0.
  - Otherwise use XOR: q_m[i]=q_m[i-1]^D[i], q_m[8]=1.
- **Stage 2:** n1q and n0q are computed from q_m[7:0].
- **Stage 3 (DC balance, DE=1):**
  - If cnt==0 or n1q==n0q: pq = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - If q_m[8]=1: cnt += n1q−n0q.
    - If q_m[8]=0: cnt += n0q−n1q.
  - Else if (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q): pq = {1, q_m[8], ~q_m[7:0]}. cnt += 2·q_m[8] + n0q − n1q.
  - Else: pq = {0, q_m[8], q_m[7:0]}. cnt += n1q − n0q − 2·~q_m[8].
- **Arithmetic:**
  - `cnt` is 5-bit two's complement; its legal range is ±8 and it never wraps.
  - n1q/n0q are 4-bit unsigned.
  - Difference terms are sign-extended to 5 bits before addition.
- **Blank monitor:**
  - Counter width is clog2(kMinBlank+1). It counts stage-3 cycles with DE=0 and saturates at `kMinBlank`.
  - On a stage-3 DE 0→1 edge: if count<kMinBlank, `pblank_short` pulses. The counter then clears.
  - DE=1 holds the counter at 0.
  - The first blanking after reset counts from 0, like any other.
- **Simultaneous/boundary cases:**
  - A DE toggle on every cycle is legal. Each data word after a token is encoded with cnt=0.
  - The saturated counter never wraps.

## Timing
- Fixed latency of 3 cycles. Inputs sampled at edge k drive `pq` after edge k+3. DE, C0 and C1 are delayed alongside the data.
- There is no handshake; one character is produced per cycle, continuously.
- `pblank_short` is registered and asserts in the same cycle `pq` carries the first data character after the short blanking.
- While `prst_n`=0 at any edge, the next cycle shows `pq`=10'h354 and `cnt`=0, and pipeline contents are discarded.
- After release, 10'h354 persists until the first post-reset input reaches stage 3, i.e. 3 cycles.

## Structure
- Shared package `tmds_pkg` holds:
  - CTRLTOKEN0..3 (10'h354, 10'h0AB, 10'h154, 10'h2AB), shared with the receive-side token detectors.
  - A token-select function of {C1,C0}.
  - The 5-bit disparity type.
- Sub-module `tmds_ones8`: combinational 8-bit popcount, instantiated twice (stages 1 and 2).
- Everything else stays in one flat module.

## Test plan
- **Reset and idle:** hold `prst_n`=0 for 5 cycles, then release with DE=0, C=00 → `pq`=10'h354 throughout; `pblank_short`=0.
- **Control tokens:** DE=0 with C=01, then 10, then 11 on consecutive cycles → `pq`=10'h0AB, 10'h154, 10'h2AB, starting 3 cycles later.
- **Disparity sequence:** after blanking, DE=1 with D=8'h00 ×3 → `pq`=10'h100, 10'h3FF, 10'h100, with cnt −8, +2, −6.
- **XNOR path:** after blanking, D=8'hFF → `pq`=10'h200, cnt=−8.
- **Blank monitor** (kMinBlank=300):
  - Blanking of 10 cycles, then DE=1 → `pblank_short` pulses once, in the cycle of the first data character on `pq`.
  - Blanking of 300 or 1000 cycles → no pulse.
- **Mid-stream reset:** drop `prst_n` for 1 cycle during active video → `pq`=10'h354 next cycle. After release, the first data word is encoded with cnt=0.
- **Random DE/data check:** 10k words against a reference model → exact `pq` match, and |cnt|≤8 at all times.
